dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the rv32i core: the target end of the `dmem_*` request interface driven by the control unit and datapath. It accepts one load or store per request, applies the configured wait states, and performs byte-lane alignment, byte-enable writes and load sign or zero extension. It reports misaligned or out-of-range accesses as errors. While a request is outstanding it holds the core with a stall.

## Interface
**Parameters**
- `MEM_WORDS`, default 1024: depth of the internal word array (32-bit words).
- `LATENCY`, default 1: wait cycles inserted between acceptance and response. Legal range is 0..15.

**Ports**
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high reset.
- `dmem_req`, in, 1: access request. Held high, with all request fields stable, until `dmem_ready`.
- `dmem_wr_en`, in, 1: 1 = store, 0 = load.
- `dmem_size`, in, `mem_size_t`: byte, halfword or word.
- `dmem_zero_extend`, in, 1: loads only. 1 = zero-extend, 0 = sign-extend.
- `dmem_addr`, in, 32: byte address.
- `dmem_wdata`, in, 32: store data, right-justified.
- `dmem_rdata`, out, 32: extended load data. Valid while `dmem_ready` is high; held until the next completion.
- `dmem_ready`, out, 1: one-cycle completion pulse.
- `dmem_err`, out, 1: qualified by `dmem_ready`. Marks a misaligned, out-of-range or reserved-size access.
- `dmem_stall`, out, 1: equals `dmem_req & ~dmem_ready` (combinational). Freezes the PC and register-file write.

## Operation
**FSM states:** `IDLE`, `WAIT`, `RESP`.
- **`IDLE`:** if `dmem_req`, latch `wr_en`, `size`, `zero_extend`, `addr` and `wdata`.
  - If `LATENCY`=0, go to `RESP`.
  - Otherwise go to `WAIT` with `cnt`=`LATENCY`-1.
- **`WAIT`:** decrement `cnt`. At `cnt`=0, go to `RESP`. Input changes are ignored after acceptance.
- **`RESP`:** `dmem_ready`=1 for exactly one cycle, then go to `IDLE`.

**Work done on the edge entering `RESP`** (uses latched fields only):
- **Error check:** error if any of the following holds.
  - Halfword with `addr[0]`=1.
  - Word with `addr[1:0]`≠0.
  - Word index `addr[31:2]` ≥ `MEM_WORDS`.
  - Reserved size encoding.
- **On error:** no memory write, `dmem_rdata`=0, `dmem_err`=1.
- **Store:** byte-enable write to word `addr[31:2]`.
  - Byte: lane `addr[1:0]`, data `wdata[7:0]`.
  - Halfword: lanes {`addr[1]`,0} and {`addr[1]`,1}, data `wdata[15:0]`.
  - Word: all four lanes.
  - `dmem_rdata` is unchanged; `dmem_err`=0.
- **Load:** extract the addressed byte or halfword lane (or the full word), extend it per `zero_extend`, and register the result into `dmem_rdata`. `dmem_err`=0.
- **Memory array:** not reset. Contents persist across `reset`.

## Timing
- **Reset values:** state=`IDLE`, `cnt`=0, `dmem_ready`=0, `dmem_err`=0, `dmem_rdata`=0. `dmem_stall` follows `dmem_req` combinationally, so it is 1 if a request is present during reset.
- **Latency:** acceptance in `IDLE` at cycle t gives `dmem_ready` at cycle t+`LATENCY`+1.
- **Throughput:** back-to-back requests complete every `LATENCY`+2 cycles, because `RESP` always returns to `IDLE` before the next acceptance.
- **Stall:** the `dmem_stall` pulse covers the `IDLE` acceptance cycle and all `WAIT` cycles. It is low in the `RESP` cycle, so the core advances on the same edge the data is consumed.
- **Reset mid-operation:**
  - Reset asserted in `WAIT` or `RESP` returns to `IDLE`.
  - A pending store is discarded unless it was written on an edge before reset.
  - No `dmem_ready` is issued for the aborted request.
- **Protocol violations:** `dmem_req` dropped during `WAIT` still completes the access and pulses `dmem_ready`. `dmem_req` with no valid instruction is the core's responsibility.

## Structure
- **`risc_pkg` additions:**
  - `dmem_state_t` (`IDLE`/`WAIT`/`RESP`).
  - `DMEM_CNT_W` = 4.
- **`risc_pkg` reuse:** existing `mem_size_t` (`byte_size`, `halfword_size`, `word_size`).
- **Sub-module `dmem_lane_align`** (combinational):
  - Store side: address + size + wdata → 4-bit byte enable + lane-replicated write data.
  - Load side: address + size + zero_extend + raw word → extended load data + misalign flag.
- **Top level:** the FSM, the latch registers, the array and range checking.

## Test plan
- **Word store and load:** `LATENCY`=1; SW 0xDEADBEEF at 0x10, then LW 0x10 → `dmem_ready` 2 cycles after each acceptance, `dmem_rdata`=0xDEADBEEF, `dmem_err`=0, `dmem_stall` high for 2 cycles per access.
- **Byte extension:** SB 0x80 at 0x13 over word 0 → memory word = 0x80000000.
  - LB 0x13 → 0xFFFFFF80.
  - LBU 0x13 → 0x00000080.
- **Halfword lanes:** SH 0x8001 at 0x22, LH 0x22 → 0xFFFF8001, LHU 0x22 → 0x00008001, word at 0x20 has bits [15:0] unchanged.
- **Misalignment:** LW 0x11, then SH 0x21 → `dmem_err`=1 with `dmem_ready`, `dmem_rdata`=0 for the load, and the memory at 0x20 is unchanged.
- **Out of range:** `MEM_WORDS`=1024, LW 0x1000 → `dmem_err`=1.
- **`LATENCY` sweep:** `LATENCY`=0 → `dmem_ready` at t+1. `LATENCY`=15 → `dmem_ready` at t+16, then back-to-back requests every 17 cycles.
- **Reset mid-`WAIT`:** `LATENCY`=4, SW 0x12345678 at 0x40, reset at t+2 → no `dmem_ready`, and a following LW 0x40 returns the prior contents.

Source files
------------

// File: rtl/risc_pkg.sv
// rtl/risc_pkg.sv - shared rv32i types: access size encoding and data-memory responder FSM
package risc_pkg;

  typedef enum logic [1:0] {
    byte_size     = 2'b00,
    halfword_size = 2'b01,
    word_size     = 2'b10
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam int DMEM_CNT_W = 4;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - core-to-data-memory request/response bundle
interface dmem_if;

  logic                dmem_req;
  logic                dmem_wr_en;
  risc_pkg::mem_size_t dmem_size;
  logic                dmem_zero_extend;
  logic [31:0]         dmem_addr;
  logic [31:0]         dmem_wdata;
  logic [31:0]         dmem_rdata;
  logic                dmem_ready;
  logic                dmem_err;
  logic                dmem_stall;

  modport master (
    output dmem_req, dmem_wr_en, dmem_size, dmem_zero_extend, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ready, dmem_err, dmem_stall
  );

  modport slave (
    input  dmem_req, dmem_wr_en, dmem_size, dmem_zero_extend, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ready, dmem_err, dmem_stall
  );

endinterface

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - byte-lane steering for stores and extension for loads
module dmem_lane_align
  import risc_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_size_t   size,
  input  logic        zero_extend,
  input  logic [31:0] wdata,
  input  logic [31:0] raw_word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        size_err
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = 32'h0;
    load_data   = 32'h0;
    misalign    = 1'b0;
    size_err    = 1'b0;
    byte_sel    = raw_word[{addr_lo, 3'b000} +: 8];
    half_sel    = addr_lo[1] ? raw_word[31:16] : raw_word[15:0];
    case (size)
      byte_size: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
        load_data   = {{24{~zero_extend & byte_sel[7]}}, byte_sel};
      end
      halfword_size: begin
        misalign    = addr_lo[0];
        byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lanes = {2{wdata[15:0]}};
        load_data   = {{16{~zero_extend & half_sel[15]}}, half_sel};
      end
      word_size: begin
        misalign    = |addr_lo;
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
        load_data   = raw_word;
      end
      default: size_err = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - wait-stated data memory target with alignment, extension and error reporting
module dmem_responder
  import risc_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int LATENCY   = 1
) (
  input  logic  clk,
  input  logic  reset,
  dmem_if.slave bus
);

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  dmem_state_t           state_q, state_d;
  logic [DMEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                  wr_en_q, wr_en_d;
  mem_size_t             size_q, size_d;
  logic                  zext_q, zext_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic             accept, enter_resp, ready;
  logic             eff_wr, eff_zext;
  mem_size_t        eff_size;
  logic [31:0]      eff_addr, eff_wdata;
  logic [IDX_W-1:0] eff_idx;
  logic             in_range, acc_err, mem_we;
  logic [31:0]      raw_word;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_lanes, load_data;
  logic             misalign, size_err;

  // In IDLE the incoming fields are the ones being latched, so a zero-latency
  // access can complete on the acceptance edge itself.
  always_comb begin
    accept     = (state_q == IDLE) && bus.dmem_req;
    eff_wr     = (state_q == IDLE) ? bus.dmem_wr_en       : wr_en_q;
    eff_size   = (state_q == IDLE) ? bus.dmem_size        : size_q;
    eff_zext   = (state_q == IDLE) ? bus.dmem_zero_extend : zext_q;
    eff_addr   = (state_q == IDLE) ? bus.dmem_addr        : addr_q;
    eff_wdata  = (state_q == IDLE) ? bus.dmem_wdata       : wdata_q;
    enter_resp = (accept && (LATENCY == 0)) || ((state_q == WAIT) && (cnt_q == '0));
    eff_idx    = eff_addr[IDX_W+1:2];
    in_range   = ({2'b00, eff_addr[31:2]} < 32'(MEM_WORDS));
    raw_word   = mem_q[eff_idx];
  end

  dmem_lane_align u_align (
    .addr_lo     (eff_addr[1:0]),
    .size        (eff_size),
    .zero_extend (eff_zext),
    .wdata       (eff_wdata),
    .raw_word    (raw_word),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data),
    .misalign    (misalign),
    .size_err    (size_err)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.dmem_req) begin
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = DMEM_CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) state_d = RESP;
        else             cnt_d   = cnt_q - DMEM_CNT_W'(1);
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d = accept ? bus.dmem_wr_en       : wr_en_q;
    size_d  = accept ? bus.dmem_size        : size_q;
    zext_d  = accept ? bus.dmem_zero_extend : zext_q;
    addr_d  = accept ? bus.dmem_addr        : addr_q;
    wdata_d = accept ? bus.dmem_wdata       : wdata_q;
    acc_err = misalign | size_err | ~in_range;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_we  = 1'b0;
    if (enter_resp) begin
      err_d = acc_err;
      if (acc_err)      rdata_d = 32'h0;
      else if (!eff_wr) rdata_d = load_data;
      mem_we = ~acc_err & eff_wr & ~reset;
    end
  end

  always_comb begin
    ready          = (state_q == RESP);
    bus.dmem_ready = ready;
    bus.dmem_stall = bus.dmem_req & ~ready;
    bus.dmem_rdata = rdata_q;
    bus.dmem_err   = err_q;
  end

  always_ff @(posedge clk) begin
    wr_en_q <= wr_en_d;
    size_q  <= size_d;
    zext_q  <= zext_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end

  // Array is deliberately left out of reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (mem_we && byte_en[b]) mem_q[eff_idx][8*b +: 8] <= wdata_lanes[8*b +: 8];
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - scoreboard bench over four responders with LATENCY 1, 0, 15 and 4
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_v;
  logic        wr_en;
  logic [1:0]  size_v;
  logic        zext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata_a [4];
  logic        ready_a [4];
  logic        err_a   [4];
  logic        stall_a [4];

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          cyc    = 0;
  exp_t        sb_q[$];
  logic [31:0] mdl [4][1024];
  logic [31:0] last_rd [4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : gd
    dmem_if bus ();
    assign bus.dmem_req         = req_v[g];
    assign bus.dmem_wr_en       = wr_en;
    assign bus.dmem_size        = risc_pkg::mem_size_t'(size_v);
    assign bus.dmem_zero_extend = zext;
    assign bus.dmem_addr        = addr;
    assign bus.dmem_wdata       = wdata;
    assign rdata_a[g]           = bus.dmem_rdata;
    assign ready_a[g]           = bus.dmem_ready;
    assign err_a[g]             = bus.dmem_err;
    assign stall_a[g]           = bus.dmem_stall;
    dmem_responder #(
      .MEM_WORDS (1024),
      .LATENCY   (g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 15 : 4)
    ) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );
  end

  function automatic int lat_of(input int idx);
    case (idx)
      0:       return 1;
      1:       return 0;
      2:       return 15;
      default: return 4;
    endcase
  endfunction

  function automatic void model(input int idx, input bit wr, input logic [1:0] sz, input bit ze,
                                input logic [31:0] a, input logic [31:0] wd,
                                output logic [31:0] rd, output logic er);
    int nb;
    int lane;
    int w;
    logic [31:0] v;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    lane = int'(a[1:0]);
    er   = (sz == 2'd3) || ((lane % nb) != 0) || (a >= 32'h1000);
    w    = int'(a[11:2]);
    v    = 32'h0;
    if (er) begin
      rd = 32'h0;
    end else if (wr) begin
      for (int b = 0; b < nb; b++) mdl[idx][w][(lane + b) * 8 +: 8] = wd[b * 8 +: 8];
      rd = last_rd[idx];
    end else begin
      for (int b = 0; b < nb; b++) v[b * 8 +: 8] = mdl[idx][w][(lane + b) * 8 +: 8];
      if (!ze && nb < 4 && v[nb * 8 - 1]) begin
        for (int b = nb; b < 4; b++) v[b * 8 +: 8] = 8'hFF;
      end
      rd = v;
    end
    last_rd[idx] = rd;
  endfunction

  task automatic access(input int idx, input bit wr, input logic [1:0] sz, input bit ze,
                        input logic [31:0] a, input logic [31:0] wd,
                        input bit b2b, input bit hold, output int rcyc);
    exp_t e;
    exp_t got_e;
    int   k;
    int   stall_n;
    bit   got;
    model(idx, wr, sz, ze, a, wd, e.rdata, e.err);
    e.lat = lat_of(idx) + 1 + (b2b ? 1 : 0);
    sb_q.push_back(e);
    wr_en = wr; size_v = sz; zext = ze; addr = a; wdata = wd;
    req_v[idx] = 1'b1;
    #1;
    stall_n = stall_a[idx] ? 1 : 0;
    k = 0;
    got = 1'b0;
    while (!got && k < 40) begin
      @(negedge clk); #1;
      k++;
      if (ready_a[idx]) got = 1'b1;
      else if (stall_a[idx]) stall_n++;
    end
    rcyc  = cyc;
    got_e = sb_q.pop_front();
    n_cmp++;
    if (!got) begin
      n_fail++;
      $display("FAIL ready_timeout dut%0d addr=%h: no ready after %0d cycles, required %0d", idx, a, k, got_e.lat);
    end else begin
      n_cmp += 4;
      if (k !== got_e.lat) begin
        n_fail++;
        $display("FAIL latency dut%0d addr=%h: got %0d required %0d", idx, a, k, got_e.lat);
      end
      if (rdata_a[idx] !== got_e.rdata) begin
        n_fail++;
        $display("FAIL rdata dut%0d addr=%h: got %h required %h", idx, a, rdata_a[idx], got_e.rdata);
      end
      if (err_a[idx] !== got_e.err) begin
        n_fail++;
        $display("FAIL err dut%0d addr=%h: got %b required %b", idx, a, err_a[idx], got_e.err);
      end
      if (stall_n !== lat_of(idx) + 1 || stall_a[idx] !== 1'b0) begin
        n_fail++;
        $display("FAIL stall dut%0d addr=%h: high %0d cycles, at ready %b; required %0d and 0",
                 idx, a, stall_n, stall_a[idx], lat_of(idx) + 1);
      end
    end
    if (!hold) begin
      req_v[idx] = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic op(input int idx, input bit wr, input logic [1:0] sz, input bit ze,
                    input logic [31:0] a, input logic [31:0] wd);
    int rc;
    access(idx, wr, sz, ze, a, wd, 1'b0, 1'b0, rc);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req_v = 4'b0000;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    req_v[0] = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      n_cmp += 3;
      if (ready_a[i] !== 1'b0) begin n_fail++; $display("FAIL reset_ready dut%0d: got %b required 0", i, ready_a[i]); end
      if (err_a[i] !== 1'b0) begin n_fail++; $display("FAIL reset_err dut%0d: got %b required 0", i, err_a[i]); end
      if (rdata_a[i] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata dut%0d: got %h required 0", i, rdata_a[i]); end
    end
    n_cmp += 2;
    if (stall_a[0] !== 1'b1) begin n_fail++; $display("FAIL reset_stall_req: got %b required 1", stall_a[0]); end
    if (stall_a[1] !== 1'b0) begin n_fail++; $display("FAIL reset_stall_idle: got %b required 0", stall_a[1]); end
    @(negedge clk);
    req_v[0] = 1'b0;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word();
    op(0, 1, 2'd2, 0, 32'h10, 32'hDEADBEEF);
    op(0, 0, 2'd2, 0, 32'h10, 32'h0);
  endtask

  task automatic test_byte_ext();
    op(0, 1, 2'd2, 0, 32'h10, 32'h0);
    op(0, 1, 2'd0, 0, 32'h13, 32'h80);
    op(0, 0, 2'd2, 0, 32'h10, 32'h0);
    op(0, 0, 2'd0, 0, 32'h13, 32'h0);
    op(0, 0, 2'd0, 1, 32'h13, 32'h0);
  endtask

  task automatic test_halfword();
    op(0, 1, 2'd2, 0, 32'h20, 32'h11223344);
    op(0, 1, 2'd1, 0, 32'h22, 32'h8001);
    op(0, 0, 2'd1, 0, 32'h22, 32'h0);
    op(0, 0, 2'd1, 1, 32'h22, 32'h0);
    op(0, 0, 2'd2, 0, 32'h20, 32'h0);
  endtask

  task automatic test_misalign();
    op(0, 0, 2'd2, 0, 32'h11, 32'h0);
    op(0, 1, 2'd1, 0, 32'h21, 32'hFFFF);
    op(0, 0, 2'd2, 0, 32'h20, 32'h0);
    op(0, 0, 2'd3, 0, 32'h20, 32'h0);
    op(0, 1, 2'd3, 0, 32'h20, 32'h55555555);
    op(0, 0, 2'd2, 0, 32'h20, 32'h0);
  endtask

  task automatic test_out_of_range();
    op(0, 0, 2'd2, 0, 32'h1000, 32'h0);
    op(0, 1, 2'd2, 0, 32'hFFC, 32'hA1B2C3D4);
    op(0, 1, 2'd2, 0, 32'h1000, 32'h0BADF00D);
    op(0, 0, 2'd2, 0, 32'hFFC, 32'h0);
    op(0, 0, 2'd0, 0, 32'hFFFF_FFFF, 32'h0);
  endtask

  task automatic test_latency_sweep();
    op(1, 1, 2'd2, 0, 32'h0, 32'hA5A5_5A5A);
    op(1, 0, 2'd1, 0, 32'h2, 32'h0);
    op(2, 1, 2'd2, 0, 32'h8, 32'h0F0F_7777);
    op(2, 0, 2'd0, 0, 32'h9, 32'h0);
  endtask

  task automatic test_back_to_back();
    int r0, r1, r2;
    access(2, 1, 2'd2, 0, 32'hC, 32'h1357_9BDF, 1'b0, 1'b1, r0);
    access(2, 0, 2'd2, 0, 32'hC, 32'h0,         1'b1, 1'b1, r1);
    access(2, 0, 2'd1, 1, 32'hE, 32'h0,         1'b1, 1'b0, r2);
    n_cmp += 2;
    if (r1 - r0 !== 17) begin n_fail++; $display("FAIL b2b_period_a: got %0d required 17", r1 - r0); end
    if (r2 - r1 !== 17) begin n_fail++; $display("FAIL b2b_period_b: got %0d required 17", r2 - r1); end
    access(0, 1, 2'd2, 0, 32'h30, 32'h2468_ACE0, 1'b0, 1'b1, r0);
    access(0, 0, 2'd0, 0, 32'h33, 32'h0,         1'b1, 1'b0, r1);
    n_cmp++;
    if (r1 - r0 !== 3) begin n_fail++; $display("FAIL b2b_period_lat1: got %0d required 3", r1 - r0); end
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    op(3, 1, 2'd2, 0, 32'h40, 32'hCAFE_F00D);
    wr_en = 1'b1; size_v = 2'd2; zext = 1'b0; addr = 32'h40; wdata = 32'h1234_5678;
    req_v[3] = 1'b1;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); #1;
      if (ready_a[3]) pulses++;
      if (i == 1) begin
        reset = 1'b1;
        req_v[3] = 1'b0;
      end
      if (i == 3) reset = 1'b0;
    end
    for (int i = 0; i < 4; i++) last_rd[i] = 32'h0;
    n_cmp += 2;
    if (pulses !== 0) begin n_fail++; $display("FAIL abort_ready: got %0d pulses required 0", pulses); end
    if (rdata_a[3] !== 32'h0) begin n_fail++; $display("FAIL abort_rdata: got %h required 0", rdata_a[3]); end
    @(negedge clk);
    op(3, 0, 2'd2, 0, 32'h40, 32'h0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 16; i++) op(0, 1, 2'd2, 0, 32'h100 + 32'(4 * i), 32'h0);
    for (int i = 0; i < 24; i++) begin
      op(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
         32'h100 + 32'($urandom_range(0, 63)), $urandom);
    end
  endtask

  initial begin
    req_v = 4'b0000; wr_en = 1'b0; size_v = 2'd0; zext = 1'b0; addr = 32'h0; wdata = 32'h0;
    reset = 1'b1;
    @(negedge clk);
    test_reset();
    test_word();
    test_byte_ext();
    test_halfword();
    test_misalign();
    test_out_of_range();
    test_latency_sweep();
    test_back_to_back();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
